// File: rtl/conversor_resultado_signado.sv
// ---------------------------------------------------------------------------
// conversor_resultado_signado
//
// Converts the sequential multiplier's magnitude/sign result into one of four
// output formats and queues the converted words in a small FIFO. The producer
// is never stalled by a slow consumer until the FIFO fills.
//
// Parameters
//   Word_Length : multiplier operand width. The result width is P = 2*Word_Length.
//   Depth       : number of FIFO entries (1..64). It does not need to be a power of two.
//
// Ports
//   clk                      rising-edge clock
//   rst_n                    asynchronous, active-low reset
//   Product_Input [P-1:0]    unsigned product magnitude
//   Sign_Input               result sign (1 = negative)
//   Mode_Input [1:0]         00 two's-complement wrap, 01 sign-magnitude,
//                            10 magnitude only, 11 two's-complement saturate
//   Valid_Input              producer offers a result
//   Ready_Output             a result is accepted this cycle (FIFO not full)
//   Product_Converted_Output converted result at the FIFO head (0 when empty)
//   Overflow_Output          overflow flag of the head entry (0 when empty)
//   Valid_Output             the head entry is valid (FIFO not empty)
//   Ready_Input              consumer takes the head entry this cycle
//   Occupancy_Output         number of stored entries
// ---------------------------------------------------------------------------
module conversor_resultado_signado #(
    parameter int Word_Length = 8,
    parameter int Depth       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [2*Word_Length-1:0]       Product_Input,
    input  logic                           Sign_Input,
    input  logic [1:0]                     Mode_Input,
    input  logic                           Valid_Input,
    output logic                           Ready_Output,
    output logic [2*Word_Length-1:0]       Product_Converted_Output,
    output logic                           Overflow_Output,
    output logic                           Valid_Output,
    input  logic                           Ready_Input,
    output logic [$clog2(Depth+1)-1:0]     Occupancy_Output
);

    localparam int P     = 2 * Word_Length;
    localparam int PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int OCC_W = $clog2(Depth + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(Depth - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(Depth);
    localparam logic [P-1:0]     HALF     = {1'b1, {(P-1){1'b0}}};
    localparam logic [P-1:0]     MAX_POS  = {1'b0, {(P-1){1'b1}}};

    // ------------------------------------------------------------------
    // Input-side conversion (combinational, applied per pushed word)
    // ------------------------------------------------------------------
    logic [P-1:0] neg_mag;
    logic [P-1:0] twos_data;
    logic         twos_ovf;
    logic [P-1:0] conv_data;
    logic         conv_ovf;

    always_comb begin
        neg_mag   = '0 - Product_Input;
        twos_data = Sign_Input ? neg_mag : Product_Input;
        // A negative result can reach -H; a positive one must stay below H.
        twos_ovf  = Sign_Input ? (Product_Input > HALF) : Product_Input[P-1];

        conv_data = Product_Input;
        conv_ovf  = 1'b0;
        case (Mode_Input)
            2'b00: begin
                conv_data = twos_data;
                conv_ovf  = twos_ovf;
            end
            2'b01: begin
                // Sign bit is suppressed for a zero magnitude so -0 reads as +0.
                conv_data = {Sign_Input & (|Product_Input), Product_Input[P-2:0]};
                conv_ovf  = Product_Input[P-1];
            end
            2'b10: begin
                conv_data = Product_Input;
                conv_ovf  = 1'b0;
            end
            2'b11: begin
                conv_ovf  = twos_ovf;
                if (twos_ovf)
                    conv_data = Sign_Input ? HALF : MAX_POS;
                else
                    conv_data = twos_data;
            end
            default: begin
                conv_data = Product_Input;
                conv_ovf  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [OCC_W-1:0] occ_next;
    logic             push;
    logic             pop;

    // Handshake flags derive from registered occupancy only, so a pop in the
    // same cycle never opens a slot for a push when full.
    assign Ready_Output = (occ_reg != FULL_OCC);
    assign Valid_Output = (occ_reg != '0);
    assign push         = Valid_Input & Ready_Output;
    assign pop          = Valid_Output & Ready_Input;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        occ_next    = occ_reg;
        if (push)
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
        if (pop)
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
        if (push && !pop)
            occ_next = occ_reg + 1'b1;
        else if (pop && !push)
            occ_next = occ_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            occ_reg    <= occ_next;
        end
    end

    // ------------------------------------------------------------------
    // Storage: {data, overflow} per entry. Contents need no reset; the
    // pointers alone decide what is visible.
    // ------------------------------------------------------------------
    logic [P:0] mem [Depth];
    logic [P:0] head_entry;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {conv_data, conv_ovf};
    end

    // Head is read directly so a word pushed into an empty FIFO is visible
    // one cycle after it was offered.
    assign head_entry = mem[rd_ptr_reg];

    assign Product_Converted_Output = Valid_Output ? head_entry[P:1] : '0;
    assign Overflow_Output          = Valid_Output ? head_entry[0]   : 1'b0;
    assign Occupancy_Output         = occ_reg;

endmodule

// File: tb/tb_conversor_resultado_signado.sv
module tb_conversor_resultado_signado;

    logic        clk;
    logic        rst_n;
    logic [15:0] prod;
    logic        sign;
    logic [1:0]  mode;
    logic        vin;
    logic        rout;
    logic [15:0] dout;
    logic        ovf;
    logic        vout;
    logic        rin;
    logic [2:0]  occ;

    int tests  = 0;
    int failed = 0;

    conversor_resultado_signado #(.Word_Length(8), .Depth(4)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .Product_Input            (prod),
        .Sign_Input               (sign),
        .Mode_Input               (mode),
        .Valid_Input              (vin),
        .Ready_Output             (rout),
        .Product_Converted_Output (dout),
        .Overflow_Output          (ovf),
        .Valid_Output             (vout),
        .Ready_Input              (rin),
        .Occupancy_Output         (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one word into an empty FIFO, check it at the head, then pop it.
    task automatic conv(input string tag, input logic [1:0] m, input logic [15:0] mag,
                        input logic s, input logic [15:0] exp_d, input logic exp_o);
        mode = m; prod = mag; sign = s; vin = 1'b1; rin = 1'b1;
        step();
        vin = 1'b0;
        check({tag, "_valid"}, 32'(vout), 32'd1);
        check({tag, "_data"}, 32'(dout), 32'(exp_d));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
        $display("[TB] conv %s mode=%b M=%h S=%b -> %h ovf=%b", tag, m, mag, s, dout, ovf);
        step();
        check({tag, "_drained"}, 32'(occ), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; prod = '0; sign = 1'b0; mode = 2'b00; vin = 1'b0; rin = 1'b0;
        #2;
        check("rst_valid", 32'(vout), 32'd0);
        check("rst_data", 32'(dout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_ready", 32'(rout), 32'd1);
        $display("[TB] reset state checked");
        step();
        rst_n = 1'b1;
        step();

        // Conversion vectors
        conv("m00_neg5",   2'b00, 16'h0005, 1'b1, 16'hFFFB, 1'b0);
        conv("m00_negH",   2'b00, 16'h8000, 1'b1, 16'h8000, 1'b0);
        conv("m00_posH",   2'b00, 16'h8000, 1'b0, 16'h8000, 1'b1);
        conv("m00_negz",   2'b00, 16'h0000, 1'b1, 16'h0000, 1'b0);
        conv("m00_negbig", 2'b00, 16'h8001, 1'b1, 16'h7FFF, 1'b1);
        conv("m11_possat", 2'b11, 16'h9000, 1'b0, 16'h7FFF, 1'b1);
        conv("m11_negsat", 2'b11, 16'h9000, 1'b1, 16'h8000, 1'b1);
        conv("m11_neg",    2'b11, 16'h1234, 1'b1, 16'hEDCC, 1'b0);
        conv("m11_negH",   2'b11, 16'h8000, 1'b1, 16'h8000, 1'b0);
        conv("m01_neg5",   2'b01, 16'h0005, 1'b1, 16'h8005, 1'b0);
        conv("m01_negz",   2'b01, 16'h0000, 1'b1, 16'h0000, 1'b0);
        conv("m01_ovf",    2'b01, 16'h8001, 1'b0, 16'h0001, 1'b1);
        conv("m10_mag",    2'b10, 16'hABCD, 1'b1, 16'hABCD, 1'b0);

        // Fill with consumer stalled, then drain
        mode = 2'b00; sign = 1'b0; rin = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            prod = 16'(i); vin = 1'b1;
            check($sformatf("fill_ready%0d", i), 32'(rout), 32'd1);
            step();
            check($sformatf("fill_occ%0d", i), 32'(occ), 32'(i));
            $display("[TB] fill push %0d occ=%0d ready=%b", i, occ, rout);
        end
        check("full_ready", 32'(rout), 32'd0);
        prod = 16'd5; vin = 1'b1;
        step();
        check("full_hold_occ", 32'(occ), 32'd4);
        check("full_head1", 32'(dout), 32'd1);
        rin = 1'b1;
        step();
        check("fullpop_occ", 32'(occ), 32'd3);
        check("fullpop_head2", 32'(dout), 32'd2);
        $display("[TB] full+pop occ=%0d head=%h", occ, dout);
        step();
        vin = 1'b0;
        check("push5_occ", 32'(occ), 32'd3);
        check("drain_head3", 32'(dout), 32'd3);
        step();
        check("drain_head4", 32'(dout), 32'd4);
        step();
        check("drain_head5", 32'(dout), 32'd5);
        check("drain_occ1", 32'(occ), 32'd1);
        step();
        check("drain_empty", 32'(vout), 32'd0);
        check("drain_data0", 32'(dout), 32'd0);
        $display("[TB] drain complete occ=%0d", occ);

        // Continuous streaming
        rin = 1'b1; vin = 1'b1; prod = 16'h0100;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("stream_occ%0d", i), 32'(occ), 32'd1);
            check($sformatf("stream_data%0d", i), 32'(dout), 32'(16'h0100 + 16'(i)));
            $display("[TB] stream %0d out=%h occ=%0d", i, dout, occ);
            prod = 16'h0100 + 16'(i + 1);
        end
        vin = 1'b0;
        step();
        check("stream_end_occ", 32'(occ), 32'd0);

        // Asynchronous reset mid-operation
        rin = 1'b0; vin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prod = 16'h00A1 + 16'(i);
            step();
        end
        check("prereset_occ", 32'(occ), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(vout), 32'd0);
        check("arst_data", 32'(dout), 32'd0);
        check("arst_occ", 32'(occ), 32'd0);
        check("arst_ready", 32'(rout), 32'd1);
        $display("[TB] async reset occ=%0d valid=%b", occ, vout);
        step();
        check("arst_hold_occ", 32'(occ), 32'd0);
        vin = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        prod = 16'h0077; vin = 1'b1; rin = 1'b1;
        step();
        vin = 1'b0;
        check("postrst_head", 32'(dout), 32'h0077);
        check("postrst_occ", 32'(occ), 32'd1);
        $display("[TB] post-reset head=%h", dout);
        step();
        check("postrst_drained", 32'(occ), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/conversor_resultado_signado.md
# conversor_resultado_signado

Registered, parametrised successor to the combinational absolute-value converter on the sequential multiplier's output path. Takes the multiplier's magnitude/sign result under a valid/ready handshake, converts it in one of four selectable output formats with overflow detection or saturation, and buffers results in a Depth-entry FIFO so the multiplier never stalls on a slow consumer. Sits between the multiplier datapath and the result consumer.

## Interface
- Word_Length, 8, multiplier operand width; result width is P = 2*Word_Length.
- Depth, 4, FIFO entries; legal range 1..64, not required to be a power of two.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- Product_Input  input  P  unsigned product magnitude.
- Sign_Input  input  1  result sign (1 = negative).
- Mode_Input  input  2  format: 00 two's-complement wrap, 01 sign-magnitude, 10 magnitude only, 11 two's-complement saturate.
- Valid_Input  input  1  producer offers a result.
- Ready_Output  output  1  block accepts a result this cycle.
- Product_Converted_Output  output  P  converted result at FIFO head.
- Overflow_Output  output  1  overflow flag of the head entry.
- Valid_Output  output  1  head entry is valid.
- Ready_Input  input  1  consumer accepts the head entry this cycle.
- Occupancy_Output  output  clog2(Depth+1)  number of stored entries.

## Operation
- Push: when Valid_Input && Ready_Output. Product, sign, and mode are sampled together, converted combinationally, and written as {data, overflow}. Mode applies per word.
- Pop: when Valid_Output && Ready_Input. The head advances.
- Ready_Output = (occupancy != Depth). When the FIFO is full, a simultaneous pop does not enable a push in that cycle.
- Valid_Output = (occupancy != 0). Product_Converted_Output and Overflow_Output are forced to 0 while Valid_Output = 0.
- Pointers wrap from Depth-1 to 0. Occupancy updates as follows:
  - push only: +1
  - pop only: −1
  - both: unchanged
- Conversion rules. M = magnitude, S = sign, H = 2^(P-1).
  - 00: data = S ? (0−M) mod 2^P : M. Overflow = S ? (M > H) : (M ≥ H). Zero with S=1 yields 0, no overflow.
  - 01: data = {S & (M≠0), M[P-2:0]}. Negative zero is normalised to +0. Overflow = M[P-1].
  - 10: data = M, sign ignored, overflow = 0.
  - 11: same as 00, except that on overflow data clamps to H−1 (S=0) or H (S=1, as bit pattern 1 followed by zeros).
- FIFO ordering is strictly first-in, first-out. No data is dropped or duplicated.

## Timing
- Reset state (asynchronous, immediate):
  - pointers and occupancy = 0
  - Valid_Output = 0, Product_Converted_Output = 0, Overflow_Output = 0
  - Ready_Output = 1 (combinational from occupancy)
  - FIFO storage contents are don't-care.
- Latency: a word pushed at edge N appears at the outputs after edge N when the FIFO was empty, i.e. one cycle from input to Valid_Output.
- Throughput is one word per cycle when Ready_Input is held high. With Depth=1, throughput is one word every 2 cycles, because push-when-full is blocked.
- Ready_Output and Valid_Output are combinational from registered occupancy only; neither depends on Valid_Input or Ready_Input.
- Reset asserted mid-operation discards all stored entries. No pop or push completes on the edge during which rst_n is low.

## Test plan
- Word_Length=8, mode 00, Ready_Input=1: expected results:
  - M=0x0005, S=1 → 0xFFFB, ovf 0.
  - M=0x8000, S=1 → 0x8000, ovf 0.
  - M=0x8000, S=0 → 0x8000, ovf 1.
  - M=0x0000, S=1 → 0x0000, ovf 0.
- Mode 11: expected results:
  - M=0x9000, S=0 → 0x7FFF, ovf 1.
  - M=0x9000, S=1 → 0x8000, ovf 1.
  - M=0x1234, S=1 → 0xEDCC, ovf 0.
- Mode 01 and mode 10: expected results:
  - 01, M=0x0005, S=1 → 0x8005.
  - 01, M=0x0000, S=1 → 0x0000.
  - 01, M=0x8001, S=0 → 0x0001, ovf 1.
  - 10, M=0xABCD, S=1 → 0xABCD, ovf 0.
- Depth=4, Ready_Input=0, offer 5 consecutive words 1..5 with mode 00 and S=0:
  - Ready_Output drops after the 4th push; Occupancy_Output = 4.
  - The 5th word is held by the producer.
  - Raising Ready_Input drains 1,2,3,4, then 5, in order.
  - No push occurs on the full-plus-pop cycle.
- Continuous push and pop with Valid_Input=1 and Ready_Input=1 for 20 cycles:
  - one word per cycle
  - Occupancy_Output stays at 1
  - output sequence equals input sequence delayed by 1 cycle.
- Fill 3 entries, assert rst_n=0 asynchronously mid-cycle:
  - Valid_Output, Product_Converted_Output, and Occupancy_Output go to 0 immediately.
  - After release, the next pushed word is the first word out.
